// File: rtl/prng_pkg.sv
// Shared types and constants for the prng_range draw engine: FSM states,
// default word width, Park-Miller constants and the mask-width helper.
package prng_pkg;

  localparam int W_DEFAULT = 32;

  localparam logic [31:0] PM_M = 32'd2147483647;
  localparam logic [31:0] PM_A = 32'd16807;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_HI,
    WAIT_LO,
    CHECK,
    OUT
  } state_t;

  // Smallest k with 2^k >= n. Returns 0 for n of 0 or 1, and 64 when no
  // 64-bit power of two is large enough.
  function automatic int mask_width(input logic [63:0] n);
    int k;
    k = 64;
    for (int i = 63; i >= 0; i--) begin
      if ((64'd1 << i) >= n) k = i;
    end
    return k;
  endfunction

endpackage

// File: rtl/prng_range_mask.sv
// Combinational range-bound to rejection-mask generator (W up to 64 bits).
module prng_range_mask
  import prng_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] n,
  output logic [W-1:0] mask
);

  logic [63:0] n_ext;
  int          k;

  // n of zero means "no bound", so the whole raw word passes through.
  always_comb begin
    n_ext = 64'(n);
    k     = mask_width(n_ext);
    if (n == '0 || k >= W) begin
      mask = '1;
    end else begin
      mask = W'((64'd1 << k) - 64'd1);
    end
  end

endmodule

// File: rtl/prng_range.sv
// Uniform draw in [0,n-1] by mask-and-reject over an external PRNG stage.
// Define PRNG_RANGE_REJECT_CNT_EN to build the saturating reject counter.
module prng_range
  import prng_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] seed_init,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] n,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         prng_start,
  output logic         prng_cont,
  output logic [W-1:0] prng_seed,
  input  logic         prng_done,
  input  logic [W-1:0] prng_rand,
  output logic [15:0]  reject_cnt
);

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] n_q;
  logic [W-1:0] mask_q;
  logic [W-1:0] mask_d;
  logic [W-1:0] rand_q;
  logic [W-1:0] seed_q;
  logic [W-1:0] cand;
  logic         accept;

  prng_range_mask #(.W(W)) u_mask (
    .n    (n),
    .mask (mask_d)
  );

  assign cand   = rand_q & mask_q;
  assign accept = (n_q == '0) || (cand < n_q);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // The PRNG handshake is a full four-phase cycle: wait for done to rise,
  // then for it to fall, before the new word is trusted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid)  state_nxt = START;
      START:                   state_nxt = WAIT_HI;
      WAIT_HI: if (prng_done)  state_nxt = WAIT_LO;
      WAIT_LO: if (!prng_done) state_nxt = CHECK;
      CHECK:                   state_nxt = accept ? OUT : START;
      OUT:     if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    prng_start = (state == START) || (state == WAIT_HI);
    out_valid  = (state == OUT);
  end

  assign prng_cont = 1'b0;
  assign prng_seed = seed_q;

  // Every drawn word becomes the next seed, whether it is accepted or not.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seed_q   <= seed_init;
      rand_q   <= '0;
      out_data <= '0;
      n_q      <= '0;
      mask_q   <= '0;
    end else begin
      if (state == IDLE && req_valid) begin
        n_q    <= n;
        mask_q <= mask_d;
      end
      if (state == WAIT_LO && !prng_done) begin
        rand_q <= prng_rand;
        seed_q <= prng_rand;
      end
      if (state == CHECK && accept) begin
        out_data <= cand;
      end
    end
  end

`ifdef PRNG_RANGE_REJECT_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      reject_cnt <= '0;
    end else if (state == CHECK && !accept && reject_cnt != 16'hFFFF) begin
      reject_cnt <= reject_cnt + 16'd1;
    end
  end
`else
  assign reject_cnt = '0;
`endif

endmodule

// File: tb/tb_prng_range.sv
// Directed bench for prng_range with a Park-Miller PRNG stage model attached.
module tb_prng_range;
  import prng_pkg::*;

  localparam int TW = 32;

`ifdef PRNG_RANGE_REJECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [TW-1:0] seed_init;
  logic          req_valid;
  logic          req_ready;
  logic [TW-1:0] n;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_data;
  logic          prng_start;
  logic          prng_cont;
  logic [TW-1:0] prng_seed;
  logic          prng_done;
  logic [TW-1:0] prng_rand;
  logic [15:0]   reject_cnt;

  int tests  = 0;
  int failed = 0;

  int model_lat = 0;
  int model_hi  = 1;

  typedef struct {
    logic [31:0] seed;
    logic [31:0] n;
    logic [31:0] data;
    logic [15:0] rej;
    logic [31:0] seed_after;
  } vec_t;

  vec_t vecs[13];

  prng_range #(.W(TW)) dut (
    .clk        (clk),
    .rst        (rst),
    .seed_init  (seed_init),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .n          (n),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .prng_start (prng_start),
    .prng_cont  (prng_cont),
    .prng_seed  (prng_seed),
    .prng_done  (prng_done),
    .prng_rand  (prng_rand),
    .reject_cnt (reject_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pmNext(input logic [31:0] s);
    logic [63:0] p;
    p = (64'(s) * 64'(PM_A)) % 64'(PM_M);
    return p[31:0];
  endfunction

  // PRNG stage model: start seen -> model_lat idle cycles -> done high for
  // model_hi cycles with the word held stable afterwards.
  logic [1:0] mphase;
  int         mcnt;

  always @(posedge clk) begin
    if (!rst) begin
      mphase    <= 2'd0;
      mcnt      <= 0;
      prng_done <= 1'b0;
      prng_rand <= '0;
    end else begin
      case (mphase)
        2'd0: if (prng_start) begin
          mphase <= 2'd1;
          mcnt   <= model_lat;
        end
        2'd1: if (mcnt == 0) begin
          prng_done <= 1'b1;
          prng_rand <= pmNext(prng_seed);
          mphase    <= 2'd2;
          mcnt      <= model_hi - 1;
        end else begin
          mcnt <= mcnt - 1;
        end
        2'd2: if (mcnt == 0) begin
          prng_done <= 1'b0;
          mphase    <= 2'd0;
        end else begin
          mcnt <= mcnt - 1;
        end
        default: mphase <= 2'd0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic doReset(input logic [31:0] s);
    rst       = 1'b0;
    seed_init = s;
    req_valid = 1'b0;
    out_ready = 1'b0;
    n         = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic sendReq(input logic [31:0] bound);
    n         = bound;
    req_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (req_ready) break;
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic waitOut(input string name);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput(name, 32'(ok), 32'd1);
  endtask

  task automatic popOut();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    doReset(v.seed);
    model_lat = idx % 3;
    model_hi  = 1 + (idx % 2);
    sendReq(v.n);
    waitOut($sformatf("v%0d_valid", idx));
    checkOutput($sformatf("v%0d_data", idx), out_data, v.data);
    checkOutput($sformatf("v%0d_rej", idx), 32'(reject_cnt), CNT_EN ? 32'(v.rej) : 32'd0);
    checkOutput($sformatf("v%0d_seed", idx), prng_seed, v.seed_after);
    popOut();
    checkOutput($sformatf("v%0d_idle", idx), {30'd0, req_ready, out_valid}, 32'b10);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit saw;

    vecs[0]  = '{32'd1, 32'd0,          32'd16807, 16'd0, 32'd16807};
    vecs[1]  = '{32'd1, 32'd10,         32'd7,     16'd0, 32'd16807};
    vecs[2]  = '{32'd1, 32'd5,          32'd1,     16'd1, 32'd282475249};
    vecs[3]  = '{32'd1, 32'd1,          32'd0,     16'd0, 32'd16807};
    vecs[4]  = '{32'd1, 32'd2,          32'd1,     16'd0, 32'd16807};
    vecs[5]  = '{32'd1, 32'd3,          32'd1,     16'd1, 32'd282475249};
    vecs[6]  = '{32'd1, 32'd16,         32'd7,     16'd0, 32'd16807};
    vecs[7]  = '{32'd1, 32'd16807,      32'd15089, 16'd1, 32'd282475249};
    vecs[8]  = '{32'd1, 32'd16808,      32'd16807, 16'd0, 32'd16807};
    vecs[9]  = '{32'd2, 32'd10,         32'd2,     16'd1, 32'd564950498};
    vecs[10] = '{32'd2, 32'd0,          32'd33614, 16'd0, 32'd33614};
    vecs[11] = '{32'd1, 32'hFFFF_FFFF,  32'd16807, 16'd0, 32'd16807};
    vecs[12] = '{32'd1, 32'h8000_0000,  32'd16807, 16'd0, 32'd16807};

    rst       = 1'b0;
    seed_init = '0;
    req_valid = 1'b0;
    out_ready = 1'b0;
    n         = '0;

    doReset(32'hDEAD_BEEF);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_prng_start", 32'(prng_start), 32'd0);
    checkOutput("rst_prng_cont", 32'(prng_cont), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_reject_cnt", 32'(reject_cnt), 32'd0);
    checkOutput("rst_prng_seed", prng_seed, 32'hDEAD_BEEF);

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], i);
    end

    // Seed chaining across requests without an intervening reset.
    doReset(32'd1);
    model_lat = 1;
    model_hi  = 2;
    sendReq(32'd5);
    waitOut("chain1_valid");
    popOut();
    sendReq(32'd0);
    waitOut("chain2_valid");
    checkOutput("chain2_data", out_data, 32'd1622650073);
    checkOutput("chain2_rej", 32'(reject_cnt), CNT_EN ? 32'd1 : 32'd0);
    checkOutput("chain2_seed", prng_seed, 32'd1622650073);
    popOut();

    // Output held under back-pressure.
    doReset(32'd1);
    model_lat = 0;
    model_hi  = 1;
    sendReq(32'd1);
    waitOut("stall_valid");
    for (int c = 0; c < 10; c++) begin
      checkOutput($sformatf("stall%0d_valid", c), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stall%0d_data", c), out_data, 32'd0);
      checkOutput($sformatf("stall%0d_ready", c), 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    checkOutput("stall_rej", 32'(reject_cnt), 32'd0);
    checkOutput("stall_seed", prng_seed, 32'd16807);
    popOut();
    checkOutput("stall_release", 32'(req_ready), 32'd1);

    // Reset landing while the engine waits for prng_done.
    doReset(32'd1);
    model_lat = 0;
    model_hi  = 1;
    sendReq(32'd0);
    waitOut("midrst_pre_valid");
    popOut();
    checkOutput("midrst_pre_seed", prng_seed, 32'd16807);
    model_lat = 6;
    sendReq(32'd0);
    repeat (2) @(negedge clk);
    checkOutput("midrst_start_hi", 32'(prng_start), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_start_lo", 32'(prng_start), 32'd0);
    checkOutput("midrst_req_ready", 32'(req_ready), 32'd1);
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_seed", prng_seed, 32'd1);
    rst = 1'b1;
    saw = 1'b0;
    for (int c = 0; c < 20; c++) begin
      saw = saw | out_valid;
      @(negedge clk);
    end
    checkOutput("midrst_no_output", 32'(saw), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
